// File: rtl/cascade_lane_align_ctrl.sv
// Per-lane receive alignment: sweeps delay taps, centres on the widest passing
// window, then bitslips until the word matches the training pattern exactly.
module cascade_lane_align_ctrl #(
  parameter int                    LANE_NUM   = 10,
  parameter int                    SER_FACTOR = 4,
  parameter int                    TAP_W      = 5,
  parameter logic [SER_FACTOR-1:0] TRAIN_PAT  = 4'b0011,
  parameter int                    SETTLE_CYC = 8,
  parameter int                    CHECK_CYC  = 16,
  localparam int                   LW = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_align_req,
  input  logic [LANE_NUM-1:0]            i_lane_mask,
  input  logic [LANE_NUM*SER_FACTOR-1:0] i_rx_data,
  output logic [LANE_NUM*TAP_W-1:0]      o_delay_val,
  output logic [LANE_NUM-1:0]            o_delay_ld,
  output logic [LANE_NUM-1:0]            o_bitslip,
  output logic [LANE_NUM-1:0]            o_lane_done,
  output logic [LANE_NUM-1:0]            o_lane_err,
  output logic                           o_busy,
  output logic                           o_align_done,
  output logic [LW-1:0]                  o_cur_lane
);

  localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(SER_FACTOR) + 1;
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, SEL, TAP_LD, SETTLE, CHECK, CENTER, SLIP_CHK, SLIP, LANE_END, FIN
  } state_t;

  state_t              state, state_nxt;
  logic [LW-1:0]       cur, sel_idx;
  logic                sel_any;
  logic [LANE_NUM-1:0] pending;
  logic [TAP_W-1:0]    tap, run_start, best_start, run_start_nxt, center;
  logic [TAP_W:0]      run_len, best_len, run_len_nxt;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       slips;
  logic                ok, in_slip;
  logic [SER_FACTOR-1:0] word;
  logic                pass_now, exact_now, last_settle, last_check;
  logic [TAP_W-1:0]    dv [LANE_NUM];

  function automatic logic is_rotation(input logic [SER_FACTOR-1:0] w);
    logic [2*SER_FACTOR-1:0] dbl;
    logic                    hit;
    dbl = {TRAIN_PAT, TRAIN_PAT};
    hit = 1'b0;
    for (int r = 0; r < SER_FACTOR; r++)
      if (dbl[r +: SER_FACTOR] == w) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = LANE_NUM - 1; k >= 0; k--)
      if (pending[k]) begin
        sel_any = 1'b1;
        sel_idx = LW'(k);
      end
    word = '0;
    for (int k = 0; k < LANE_NUM; k++)
      if (cur == LW'(k)) word = i_rx_data[k*SER_FACTOR +: SER_FACTOR];
  end

  // ok accumulates the per-word result across one check window
  assign pass_now      = ok & is_rotation(word);
  assign exact_now     = ok & (word == TRAIN_PAT);
  assign last_settle   = (cnt == CW'(SETTLE_CYC - 1));
  assign last_check    = (cnt == CW'(CHECK_CYC - 1));
  assign run_len_nxt   = pass_now ? run_len + (TAP_W+1)'(1) : '0;
  assign run_start_nxt = (pass_now && run_len == '0) ? tap : run_start;
  assign center        = best_start + best_len[TAP_W:1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: if (i_align_req) state_nxt = SEL;
      SEL:       state_nxt = sel_any ? TAP_LD : FIN;
      TAP_LD:    state_nxt = SETTLE;
      SETTLE:    if (last_settle) state_nxt = in_slip ? SLIP_CHK : CHECK;
      CHECK:     if (last_check) state_nxt = (tap == TAP_MAX) ? CENTER : TAP_LD;
      CENTER:    state_nxt = (best_len == '0) ? LANE_END : SETTLE;
      SLIP_CHK:
        if (last_check) begin
          if (exact_now || slips == SW'(SER_FACTOR - 1)) state_nxt = LANE_END;
          else                                           state_nxt = SLIP;
        end
      SLIP:      state_nxt = SETTLE;
      LANE_END:  state_nxt = SEL;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur <= '0; pending <= '0; tap <= '0; cnt <= '0; slips <= '0;
      ok <= 1'b0; in_slip <= 1'b0;
      run_start <= '0; run_len <= '0; best_start <= '0; best_len <= '0;
      o_delay_ld <= '0; o_bitslip <= '0; o_lane_done <= '0; o_lane_err <= '0;
      for (int k = 0; k < LANE_NUM; k++) dv[k] <= '0;
    end else begin
      o_delay_ld <= '0;
      o_bitslip  <= '0;
      case (state)
        IDLE, FIN:
          if (i_align_req) begin
            pending     <= i_lane_mask;
            o_lane_done <= '0;
            o_lane_err  <= '0;
          end
        SEL: begin
          cur <= sel_idx; tap <= '0; in_slip <= 1'b0; slips <= '0;
          run_start <= '0; run_len <= '0; best_start <= '0; best_len <= '0;
        end
        TAP_LD: begin
          dv[cur]         <= tap;
          o_delay_ld[cur] <= 1'b1;
          cnt             <= '0;
        end
        SETTLE: begin
          ok  <= 1'b1;
          cnt <= last_settle ? '0 : cnt + CW'(1);
        end
        CHECK: begin
          ok  <= pass_now;
          cnt <= cnt + CW'(1);
          if (last_check) begin
            // Best is replaced only by a strictly longer run, so ties keep the first
            run_len   <= run_len_nxt;
            run_start <= run_start_nxt;
            if (run_len_nxt > best_len) begin
              best_len   <= run_len_nxt;
              best_start <= run_start_nxt;
            end
            tap <= tap + TAP_W'(1);
            cnt <= '0;
          end
        end
        CENTER: begin
          o_delay_ld[cur] <= 1'b1;
          cnt             <= '0;
          if (best_len == '0) begin
            dv[cur]         <= '0;
            o_lane_err[cur] <= 1'b1;
          end else begin
            dv[cur] <= center;
            in_slip <= 1'b1;
          end
        end
        SLIP_CHK: begin
          ok  <= exact_now;
          cnt <= cnt + CW'(1);
          if (last_check) begin
            cnt <= '0;
            if (exact_now)                           o_lane_done[cur] <= 1'b1;
            else if (slips == SW'(SER_FACTOR - 1))   o_lane_err[cur]  <= 1'b1;
          end
        end
        SLIP: begin
          o_bitslip[cur] <= 1'b1;
          slips          <= slips + SW'(1);
          cnt            <= '0;
        end
        LANE_END: pending[cur] <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANE_NUM; g++) begin : g_dv
    assign o_delay_val[g*TAP_W +: TAP_W] = dv[g];
  end

  assign o_busy       = (state != IDLE) && (state != FIN);
  assign o_align_done = (state == FIN);
  assign o_cur_lane   = o_busy ? cur : '0;

endmodule

// File: doc/cascade_lane_align_ctrl.md
CASCADE_LANE_ALIGN_CTRL -- requirements
Module: cascade_lane_align_ctrl

Interface
REQ-001 SHALL have parameter LANE_NUM, default 10: number of receive lanes (1..32).
REQ-002 SHALL have parameter SER_FACTOR, default 4: deserialised word width per lane (2..8).
REQ-003 SHALL have parameter TAP_W, default 5: delay tap width; taps are 0..2^TAP_W-1.
REQ-004 SHALL have parameter TRAIN_PAT, default 4'b0011: SER_FACTOR-bit training word.
REQ-005 SHALL have parameter SETTLE_CYC, default 8: wait cycles after any tap load or bitslip.
REQ-006 SHALL have parameter CHECK_CYC, default 16: number of words compared per check.
REQ-007 SHALL have port i_clk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-008 SHALL have port i_rst  in  1  reset, asynchronous and active-high.
REQ-009 SHALL have port i_align_req  in  1  single-cycle start pulse.
REQ-010 SHALL have port i_lane_mask  in  LANE_NUM  1 = lane takes part; sampled on the accepted request.
REQ-011 SHALL have port i_rx_data  in  LANE_NUM*SER_FACTOR  lane k at [k*SER_FACTOR +: SER_FACTOR].
REQ-012 SHALL have port o_delay_val  out  LANE_NUM*TAP_W  lane k tap at [k*TAP_W +: TAP_W].
REQ-013 SHALL have port o_delay_ld  out  LANE_NUM  one-cycle strobe, asserted with a new o_delay_val.
REQ-014 SHALL have port o_bitslip  out  LANE_NUM  one-cycle bitslip pulse.
REQ-015 SHALL have ports o_lane_done and o_lane_err  out  LANE_NUM  per-lane result flags.
REQ-016 SHALL have ports o_busy and o_align_done  out  1, and o_cur_lane  out  $clog2(LANE_NUM) (minimum 1 bit).

Function
REQ-017 SHALL implement the FSM IDLE -> SEL -> TAP_LD -> SETTLE -> CHECK -> (next tap or CENTER) -> SLIP_CHK -> LANE_END -> SEL ... -> FIN.
REQ-018 SHALL accept i_align_req only in IDLE or FIN; acceptance clears all o_lane_done, o_lane_err and o_align_done and latches the mask; a request while busy SHALL be ignored.
REQ-019 SEL SHALL pick the lowest-index unprocessed masked lane; if none remains, go to FIN.
REQ-020 SHALL drive o_cur_lane with the selected lane index while o_busy = 1 (o_busy = 1 in all states except IDLE and FIN).
REQ-021 Sweep: for tap t = 0..2^TAP_W-1, TAP_LD SHALL output t with a one-cycle o_delay_ld, wait SETTLE_CYC cycles, then compare CHECK_CYC consecutive words.
REQ-022 A tap SHALL pass only if all CHECK_CYC words equal some rotation of TRAIN_PAT; the check always runs the full CHECK_CYC cycles.
REQ-023 SHALL track the longest contiguous run of passing taps; on equal lengths the first run is kept; a run ending at the maximum tap SHALL be closed.
REQ-024 CENTER SHALL load tap = start + floor(len/2), computed in TAP_W bits with no overflow, with o_delay_ld, then SETTLE.
REQ-025 SLIP_CHK SHALL require CHECK_CYC words exactly equal to TRAIN_PAT; on any mismatch it SHALL pulse o_bitslip for one cycle, settle, and recheck, allowing at most SER_FACTOR-1 slips.
REQ-026 A lane SHALL set o_lane_done on exact match; with no passing tap it SHALL instead load tap 0 and set o_lane_err; after exhausting the slips it SHALL set o_lane_err and keep the centre tap.
REQ-027 Only the lane under o_cur_lane SHALL ever receive o_delay_ld or o_bitslip; o_delay_val of other lanes SHALL hold.
REQ-028 FIN SHALL assert o_align_done, holding it until the next accepted request or reset; an all-zero mask SHALL go straight to FIN, with o_align_done asserted within 3 cycles of the request.

Reset
REQ-029 While i_rst = 1, SHALL force the FSM to IDLE and all outputs to 0, including o_delay_val; reset mid-sweep SHALL discard all progress.
REQ-030 After reset is released, the block SHALL stay idle until a new i_align_req.

Verification
REQ-031 Test configuration: LANE_NUM=2, TAP_W=3, SER_FACTOR=4, TRAIN_PAT=4'b0011; the lane model rotates data by one bit per bitslip.
REQ-032 Reset asserted mid-CHECK -> all outputs 0 and o_busy=0 within one cycle; a later request realigns the lanes.
REQ-033 Lane 0 passes taps 2..6, data already 0011 -> o_delay_val[2:0]=4, zero bitslips, o_lane_done[0]=1.
REQ-034 Lane 1 passes taps 1..2 and 4..7, data 0110 needing 3 slips to become 0011 -> tap 6, 3 o_bitslip[1] pulses, o_lane_done[1]=1.
REQ-035 Lane 0 never passes -> o_lane_err[0]=1, tap 0; lane 1 still aligned; o_align_done=1.
REQ-036 Mask 2'b10 -> lane 0 gets no strobes, o_lane_done=2'b10; a second i_align_req while busy is ignored.
